// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg: register map, frame size and FSM encoding shared by the SPI config target
package spi_pwm_pkg;
  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
  localparam int FRAME_BITS = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
endpackage

// File: rtl/spi_pwm_config_sync_ff.sv
// sync_ff: multi-stage single-bit synchroniser with a selectable reset value
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= {STAGES{RST_VAL}};
    else ff_q <= {ff_q[STAGES-2:0], d};
  assign q = ff_q[STAGES-1];
endmodule

// File: rtl/spi_pwm_config.sv
// spi_pwm_config: SPI mode-0 write-only target that loads the PWM peripheral's control registers
module spi_pwm_config
  import spi_pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_pwm_pkg::FRAME_BITS,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  logic sclk_s, copi_s, ncs_s, sclk_prev_q, ncs_prev_q;
  logic sclk_rise, ncs_rise, ncs_fall, commit;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [6:0] addr;
  logic [7:0] data;
  logic [7:0] regs_q [NUM_REGS];
  logic wr_strobe_q;
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s));
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign addr = shift_q[FRAME_BITS-2 -: 7];
  assign data = shift_q[7:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: if (ncs_fall) begin
        state_d = SHIFT;
        cnt_d   = '0;
        shift_d = '0;
      end
      // nCS rise wins over a simultaneous SCLK rise so a trailing edge is never counted
      SHIFT: if (ncs_rise) state_d = COMMIT;
      else if (sclk_rise && !ncs_s) begin
        shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
        cnt_d   = (cnt_q == CNT_W'(FRAME_BITS + 1)) ? cnt_q : cnt_q + 1'b1;
      end
      COMMIT: begin
        state_d = IDLE;
        commit  = (cnt_q == CNT_W'(FRAME_BITS)) && shift_q[FRAME_BITS-1] && (addr < 7'(NUM_REGS));
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      wr_strobe_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      wr_strobe_q <= commit;
      for (int i = 0; i < NUM_REGS; i++) if (commit && addr == 7'(i)) regs_q[i] <= data;
    end
  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY];
  assign wr_strobe       = wr_strobe_q;
endmodule

// File: tb/tb_spi_pwm_config.sv
// tb_spi_pwm_config: directed SPI write/read/malformed-frame checks on the PWM config target
module tb_spi_pwm_config;
  localparam int S = 2;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] r0, r1, r2, r3, r4;
  logic wr_strobe;
  int n_checks = 0, n_fails = 0, n_strobes = 0;
  logic [7:0] exp_regs [5];

  spi_pwm_config #(.SYNC_STAGES(S), .FRAME_BITS(16), .NUM_REGS(5)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .wr_strobe(wr_strobe)
  );

  always #50 clk = ~clk;
  always @(negedge clk) if (wr_strobe === 1'b1) n_strobes++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_r0"}, {24'h0, r0}, {24'h0, exp_regs[0]});
    chk({tag, "_r1"}, {24'h0, r1}, {24'h0, exp_regs[1]});
    chk({tag, "_r2"}, {24'h0, r2}, {24'h0, exp_regs[2]});
    chk({tag, "_r3"}, {24'h0, r3}, {24'h0, exp_regs[3]});
    chk({tag, "_r4"}, {24'h0, r4}, {24'h0, exp_regs[4]});
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = d[i];
      clks(50);
      sclk = 1'b1;
      clks(50);
      sclk = 1'b0;
    end
  endtask

  // Raises nCS and checks the strobe lands exactly S+2 edges after the first edge seeing nCS high
  task automatic end_frame(input string tag, input logic exp_stb, input logic coincide);
    clks(50);
    ncs = 1'b1;
    if (coincide) sclk = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1 chk({tag, "_pre"}, {31'h0, wr_strobe}, 32'h0);
    @(posedge clk);
    #1 chk({tag, "_stb"}, {31'h0, wr_strobe}, {31'h0, exp_stb});
    @(posedge clk);
    #1 chk({tag, "_post"}, {31'h0, wr_strobe}, 32'h0);
    clks(1);
    sclk = 1'b0;
    clks(6);
  endtask

  task automatic frame(input string tag, input logic [31:0] d, input int n, input logic exp_stb, input logic coincide);
    ncs = 1'b0;
    clks(10);
    shift_bits(d, n);
    end_frame(tag, exp_stb, coincide);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    clks(3);
    chk_regs("reset");
    chk("reset_stb", {31'h0, wr_strobe}, 32'h0);
    rst_n = 1'b1;
    clks(5);
    frame("w80F0", 32'h80F0, 16, 1'b1, 1'b0);
    exp_regs[0] = 8'hF0;
    chk_regs("w80F0");
    frame("w8480", 32'h8480, 16, 1'b1, 1'b0);
    frame("w8233", 32'h8233, 16, 1'b1, 1'b0);
    exp_regs[4] = 8'h80;
    exp_regs[2] = 8'h33;
    chk_regs("b2b");
    chk("b2b_strobes", n_strobes, 3);
    frame("rd0055", 32'h0055, 16, 1'b0, 1'b0);
    frame("bad_addr", 32'h8555, 16, 1'b0, 1'b0);
    frame("short15", 32'h4008, 15, 1'b0, 1'b0);
    frame("long17", 32'h18011, 17, 1'b0, 1'b0);
    chk_regs("invalid");
    chk("invalid_strobes", n_strobes, 3);
    ncs = 1'b0;
    clks(10);
    shift_bits(32'h81, 8);
    rst_n = 1'b0;
    clks(3);
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    chk_regs("midrst");
    rst_n = 1'b1;
    clks(3);
    shift_bits(32'hFF, 8);
    end_frame("midrst_tail", 1'b0, 1'b0);
    chk_regs("midrst_tail");
    frame("w81FF", 32'h81FF, 16, 1'b1, 1'b0);
    exp_regs[1] = 8'hFF;
    chk_regs("w81FF");
    frame("w83AA", 32'h83AA, 16, 1'b1, 1'b0);
    exp_regs[3] = 8'hAA;
    chk_regs("w83AA");
    frame("w8355_coinc", 32'h8355, 16, 1'b1, 1'b1);
    exp_regs[3] = 8'h55;
    chk_regs("w8355");
    clks(200);
    chk_regs("hold");
    chk("total_strobes", n_strobes, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
